uart_rx_word_loader: RTL

Downstream consumer of the UART receiver. It assembles received bytes, least-significant byte first, into 32-bit words. Each complete word is issued as a one-cycle write to instruction/data memory at an auto-incrementing word address. An idle-gap timeout ends a download, so the CPU program can be loaded over UART without a length header.

---
 rtl/uart_rx_word_loader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uart_rx_word_loader.sv
// uart_rx_word_loader: packs UART bytes LSB-first into 32-bit words
// and writes them to memory; an idle gap ends the download.
module uart_rx_word_loader #(
  parameter int ADDR_WIDTH     = 14,
  parameter int BASE_ADDR      = 0,
  parameter int TIMEOUT_CYCLES = 10000000
) (
  input  logic                  I_clk,
  input  logic                  I_rst_n,
  input  logic                  I_load_en,
  input  logic                  I_rx_done,
  input  logic [7:0]            I_para_data,
  output logic                  O_wr_en,
  output logic [ADDR_WIDTH-1:0] O_wr_addr,
  output logic [31:0]           O_wr_data,
  output logic                  O_busy,
  output logic                  O_load_done,
  output logic [ADDR_WIDTH:0]   O_word_cnt,
  output logic                  O_overflow
);

  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE = TW'(1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE =
    (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0] CAP =
    {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] BASE =
    ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    COLLECT,
    DONE
  } state_t;

  state_t          state;
  logic [1:0]      byte_idx;
  logic [23:0]     asm_q;
  logic [TW-1:0]   tmo_cnt;

  logic [ADDR_WIDTH:0]   cnt_inc;
  logic [ADDR_WIDTH-1:0] addr_nxt;

  assign cnt_inc  = O_word_cnt + CNT_ONE;
  assign addr_nxt = BASE + O_word_cnt[ADDR_WIDTH-1:0];

  // Loader FSM: byte assembly, word writes, timeout and capacity.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state       <= IDLE;
      byte_idx    <= 2'd0;
      asm_q       <= 24'd0;
      tmo_cnt     <= '0;
      O_wr_en     <= 1'b0;
      O_wr_addr   <= '0;
      O_wr_data   <= 32'd0;
      O_busy      <= 1'b0;
      O_load_done <= 1'b0;
      O_word_cnt  <= '0;
      O_overflow  <= 1'b0;
    end else begin
      O_wr_en <= 1'b0;
      if (!I_load_en) begin
        state       <= IDLE;
        O_busy      <= 1'b0;
        O_load_done <= 1'b0;
        byte_idx    <= 2'd0;
        asm_q       <= 24'd0;
        tmo_cnt     <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            state      <= WAIT;
            O_busy     <= 1'b1;
            O_word_cnt <= '0;
            O_overflow <= 1'b0;
            byte_idx   <= 2'd0;
            asm_q      <= 24'd0;
            tmo_cnt    <= '0;
          end
          WAIT, COLLECT: begin
            if (I_rx_done) begin
              state    <= COLLECT;
              tmo_cnt  <= '0;
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'd3) begin
                O_wr_en    <= 1'b1;
                O_wr_addr  <= addr_nxt;
                O_wr_data  <= {I_para_data, asm_q};
                O_word_cnt <= cnt_inc;
                asm_q      <= 24'd0;
                if (cnt_inc == CAP) begin
                  state       <= DONE;
                  O_busy      <= 1'b0;
                  O_load_done <= 1'b1;
                end
              end else begin
                case (byte_idx)
                  2'd0:    asm_q[7:0]   <= I_para_data;
                  2'd1:    asm_q[15:8]  <= I_para_data;
                  default: asm_q[23:16] <= I_para_data;
                endcase
              end
            end else if (state == COLLECT) begin
              if (tmo_cnt == TMO_LAST) begin
                if (byte_idx != 2'd0) begin
                  O_wr_en    <= 1'b1;
                  O_wr_addr  <= addr_nxt;
                  O_wr_data  <= {8'h00, asm_q};
                  O_word_cnt <= cnt_inc;
                end
                asm_q       <= 24'd0;
                byte_idx    <= 2'd0;
                tmo_cnt     <= '0;
                state       <= DONE;
                O_busy      <= 1'b0;
                O_load_done <= 1'b1;
              end else begin
                tmo_cnt <= tmo_cnt + TMO_ONE;
              end
            end
          end
          DONE: begin
            if (I_rx_done && (O_word_cnt == CAP))
              O_overflow <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
